// File: rtl/key_event_decoder_pkg.sv
// Shared definitions for the key event decoder and consumers of event_code.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: one-hot FSM state encoding and the 2-bit event codes reported on
// event_code. The UART-side consumer imports this package to decode event_code.
package key_event_decoder_pkg;

    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        PRESS1 = 5'b00010,
        WAIT2  = 5'b00100,
        PRESS2 = 5'b01000,
        LONG   = 5'b10000
    } state_e;

    localparam logic [1:0] EVT_SHORT  = 2'd0;
    localparam logic [1:0] EVT_DOUBLE = 2'd1;
    localparam logic [1:0] EVT_LONG   = 2'd2;
    localparam logic [1:0] EVT_REPEAT = 2'd3;

endpackage

// File: rtl/evt_timer.sv
// Per-state cycle counter with a terminal-count flag for the key event FSM.
// Latency: cnt updates one cycle after clr/en; hit is combinational from cnt.
// Backpressure: none.
//
// Ports: Clk/Rst_n clock and async active-low reset; clr forces cnt to 0 next
// cycle (wins over en); en increments cnt; limit is the timeout length N;
// cnt is the current count; hit is high in the Nth cycle (cnt == N-1).
module evt_timer #(
    parameter int CNT_W = 27
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] cnt,
    output logic             hit
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign hit = (cnt_q == limit - CNT_W'(1));

endmodule

// File: rtl/key_event_decoder.sv
// Classifies debounced key activity into short press, double click, long press and auto-repeat.
// Latency: every event pulse is registered, 1 cycle after the triggering strobe or timeout cycle.
// Backpressure: none; pulses are fire-and-forget, event_code holds the last reported event.
//
// Ports: Clk, Rst_n (async active-low); key_flag one-cycle edge strobe with
// key_state level (0 pressed, 1 released); short_press/double_click/long_press/
// repeat_pulse one-cycle event pulses; event_valid pulses with any of them;
// event_code encodes the most recent event (EVT_* in the package).
module key_event_decoder
    import key_event_decoder_pkg::*;
#(
    parameter int LONG_CNT   = 75_000_000,
    parameter int DCLICK_CNT = 15_000_000,
    parameter int REPEAT_CNT = 10_000_000,
    parameter int CNT_W      = 27
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       key_flag,
    input  logic       key_state,
    output logic       short_press,
    output logic       double_click,
    output logic       long_press,
    output logic       repeat_pulse,
    output logic       event_valid,
    output logic [1:0] event_code
);

    state_e           state_q, state_d;
    logic             short_q, short_d;
    logic             double_q, double_d;
    logic             long_q, long_d;
    logic             repeat_q, repeat_d;
    logic             valid_q, valid_d;
    logic [1:0]       code_q, code_d;

    logic             press_ev;
    logic             release_ev;
    logic             rep_restart;
    logic             tmr_clr;
    logic             tmr_en;
    logic             tmr_hit;
    logic [CNT_W-1:0] tmr_limit;
    // Count is exposed by the timer for debug visibility; the FSM only needs hit.
    logic [CNT_W-1:0] cnt_unused;

    assign press_ev   = key_flag & ~key_state;
    assign release_ev = key_flag &  key_state;

    always_comb begin
        state_d     = state_q;
        short_d     = 1'b0;
        double_d    = 1'b0;
        long_d      = 1'b0;
        repeat_d    = 1'b0;
        code_d      = code_q;
        rep_restart = 1'b0;
        // Key events are tested before hit so an edge landing on the timeout
        // cycle takes priority. Mismatched strobes fall through untouched and
        // therefore neither change state nor clear the counter.
        case (state_q)
            IDLE: begin
                if (press_ev) state_d = PRESS1;
            end
            PRESS1: begin
                if (release_ev) begin
                    state_d = WAIT2;
                end else if (tmr_hit) begin
                    state_d = LONG;
                    long_d  = 1'b1;
                    code_d  = EVT_LONG;
                end
            end
            WAIT2: begin
                if (press_ev) begin
                    state_d = PRESS2;
                end else if (tmr_hit) begin
                    state_d = IDLE;
                    short_d = 1'b1;
                    code_d  = EVT_SHORT;
                end
            end
            PRESS2: begin
                if (release_ev) begin
                    state_d  = IDLE;
                    double_d = 1'b1;
                    code_d   = EVT_DOUBLE;
                end
            end
            LONG: begin
                if (release_ev) begin
                    state_d = IDLE;
                end else if (tmr_hit) begin
                    repeat_d    = 1'b1;
                    code_d      = EVT_REPEAT;
                    rep_restart = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        valid_d = short_d | double_d | long_d | repeat_d;
    end

    // The timeout length follows the state currently being timed.
    always_comb begin
        tmr_limit = CNT_W'(LONG_CNT);
        case (state_q)
            WAIT2:   tmr_limit = CNT_W'(DCLICK_CNT);
            LONG:    tmr_limit = CNT_W'(REPEAT_CNT);
            default: tmr_limit = CNT_W'(LONG_CNT);
        endcase
    end

    // Restart on every transition (and on each repeat period) so each state
    // measures time from its own entry; IDLE and PRESS2 never advance.
    assign tmr_clr = (state_d != state_q) | rep_restart;
    assign tmr_en  = (state_q == PRESS1) | (state_q == WAIT2) | (state_q == LONG);

    evt_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .limit (tmr_limit),
        .cnt   (cnt_unused),
        .hit   (tmr_hit)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= IDLE;
            short_q  <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
            valid_q  <= 1'b0;
            code_q   <= EVT_SHORT;
        end else begin
            state_q  <= state_d;
            short_q  <= short_d;
            double_q <= double_d;
            long_q   <= long_d;
            repeat_q <= repeat_d;
            valid_q  <= valid_d;
            code_q   <= code_d;
        end
    end

    assign short_press  = short_q;
    assign double_click = double_q;
    assign long_press   = long_q;
    assign repeat_pulse = repeat_q;
    assign event_valid  = valid_q;
    assign event_code   = code_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Self-checking bench for key_event_decoder with LONG=100, DCLICK=40, REPEAT=20.
// A timestamp/deadline reference model predicts every output each cycle;
// directed scenarios pin event timing with hand-computed offsets.
module tb_key_event_decoder;

    localparam int LONG_N   = 100;
    localparam int DCLICK_N = 40;
    localparam int REPEAT_N = 20;

    logic       Clk;
    logic       Rst_n;
    logic       key_flag;
    logic       key_state;
    logic       short_press;
    logic       double_click;
    logic       long_press;
    logic       repeat_pulse;
    logic       event_valid;
    logic [1:0] event_code;

    key_event_decoder #(
        .LONG_CNT   (LONG_N),
        .DCLICK_CNT (DCLICK_N),
        .REPEAT_CNT (REPEAT_N),
        .CNT_W      (8)
    ) dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .key_flag     (key_flag),
        .key_state    (key_state),
        .short_press  (short_press),
        .double_click (double_click),
        .long_press   (long_press),
        .repeat_pulse (repeat_pulse),
        .event_valid  (event_valid),
        .event_code   (event_code)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    logic chk_on = 1'b0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks which phase of a gesture we are in and the cycle at which that
    // phase began; an event fires when the elapsed time reaches its window.
    localparam int P_IDLE = 0, P_HELD1 = 1, P_GAP = 2, P_HELD2 = 3, P_LONG = 4;
    int   phase = P_IDLE;
    int   mark  = 0;
    int   fire;
    logic exp_s = 0, exp_d = 0, exp_l = 0, exp_r = 0, exp_v = 0;
    logic [1:0] exp_code = 2'd0;

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            phase = P_IDLE; mark = 0;
            exp_s = 0; exp_d = 0; exp_l = 0; exp_r = 0; exp_v = 0; exp_code = 2'd0;
        end else begin
            fire = -1;
            case (phase)
                P_IDLE:  if (key_flag && !key_state) begin phase = P_HELD1; mark = cyc; end
                P_HELD1: if (key_flag && key_state) begin phase = P_GAP; mark = cyc; end
                         else if (cyc - mark == LONG_N) begin fire = 2; phase = P_LONG; mark = cyc; end
                P_GAP:   if (key_flag && !key_state) phase = P_HELD2;
                         else if (cyc - mark == DCLICK_N) begin fire = 0; phase = P_IDLE; end
                P_HELD2: if (key_flag && key_state) begin fire = 1; phase = P_IDLE; end
                default: if (key_flag && key_state) phase = P_IDLE;
                         else if (cyc - mark == REPEAT_N) begin fire = 3; mark = cyc; end
            endcase
            exp_s = (fire == 0); exp_d = (fire == 1); exp_l = (fire == 2); exp_r = (fire == 3);
            exp_v = (fire >= 0);
            if (fire >= 0) exp_code = fire[1:0];
        end
    end

    // ---------------- compare process ----------------
    int m_s = 0, m_d = 0, m_l = 0, m_r = 0, m_v = 0;
    int m_s_cyc = 0, m_d_cyc = 0, m_l_cyc = 0, m_r_cyc = 0;
    int d_pulse = 0, d_valid = 0;

    always @(negedge Clk) begin
        if (chk_on) begin
            chk("short_press",  short_press,  exp_s);
            chk("double_click", double_click, exp_d);
            chk("long_press",   long_press,   exp_l);
            chk("repeat_pulse", repeat_pulse, exp_r);
            chk("event_valid",  event_valid,  exp_v);
            chk("event_code",   event_code,   exp_code);
            chk("single_pulse",
                int'($countones({short_press, double_click, long_press, repeat_pulse}) <= 1), 1);
            d_pulse += $countones({short_press, double_click, long_press, repeat_pulse});
            d_valid += int'(event_valid);
            if (exp_s) begin m_s++; m_s_cyc = cyc; end
            if (exp_d) begin m_d++; m_d_cyc = cyc; end
            if (exp_l) begin m_l++; m_l_cyc = cyc; end
            if (exp_r) begin m_r++; m_r_cyc = cyc; end
            if (exp_v) m_v++;
        end
    end

    // ---------------- stimulus ----------------
    int b_s, b_d, b_l, b_r;
    int p, r, p2, r2, x;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // Strobe is sampled at the next edge; 'at' is the cycle stamp the model
    // will associate with it.
    task automatic strobe(input logic lvl, output int at);
        at = cyc;
        key_flag = 1'b1;
        key_state = lvl;
        tick();
        key_flag = 1'b0;
    endtask

    task automatic snap();
        b_s = m_s; b_d = m_d; b_l = m_l; b_r = m_r;
    endtask

    initial begin
        Rst_n = 1'b0; key_flag = 1'b0; key_state = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        chk_on = 1'b1;
        Rst_n = 1'b1;
        idle(2);
        chk("reset_code",  event_code, 0);
        chk("reset_valid", event_valid, 0);

        // short press: release 30 after press, short 41 after release
        snap();
        strobe(1'b0, p); idle(29); strobe(1'b1, r); idle(60);
        chk("short_latency", m_s_cyc - r, 41);
        chk("short_count",   m_s - b_s, 1);
        chk("short_no_long", m_l - b_l, 0);

        // double click
        snap();
        strobe(1'b0, p); idle(9); strobe(1'b1, r); idle(19);
        strobe(1'b0, p2); idle(9); strobe(1'b1, r2); idle(60);
        chk("double_latency", m_d_cyc - r2, 1);
        chk("double_count",   m_d - b_d, 1);
        chk("double_no_short", m_s - b_s, 0);

        // long press held 200 cycles: long at +101, repeats at +121..+181,
        // the one due with the release is suppressed
        snap();
        strobe(1'b0, p); idle(199); strobe(1'b1, r); idle(60);
        chk("long_latency",   m_l_cyc - p, 101);
        chk("long_count",     m_l - b_l, 1);
        chk("repeat_count",   m_r - b_r, 4);
        chk("repeat_last",    m_r_cyc - p, 181);
        chk("long_no_short",  m_s - b_s, 0);

        // release on the long-timeout cycle wins
        snap();
        strobe(1'b0, p); idle(99); strobe(1'b1, r); idle(60);
        chk("prio_release_long", m_l - b_l, 0);
        chk("prio_release_short_lat", m_s_cyc - r, 41);

        // second press on the double-click timeout cycle wins
        snap();
        strobe(1'b0, p); idle(9); strobe(1'b1, r); idle(39);
        strobe(1'b0, p2); idle(9); strobe(1'b1, r2); idle(60);
        chk("prio_press_short",  m_s - b_s, 0);
        chk("prio_press_double", m_d - b_d, 1);

        // stray release in IDLE and duplicate press in PRESS1 are ignored
        snap();
        strobe(1'b1, x); idle(5);
        strobe(1'b0, p); idle(9); strobe(1'b0, x); idle(19); strobe(1'b1, r); idle(60);
        chk("stray_short_lat", m_s_cyc - r, 41);
        chk("stray_short_cnt", m_s - b_s, 1);

        // reset while in LONG: no pending event afterwards
        snap();
        strobe(1'b0, p); idle(149);
        Rst_n = 1'b0;
        idle(1);
        chk("rst_mid_code",  event_code, 0);
        chk("rst_mid_valid", event_valid, 0);
        idle(2);
        Rst_n = 1'b1;
        idle(2);
        strobe(1'b1, r); idle(60);
        chk("rst_long_count",   m_l - b_l, 1);
        chk("rst_repeat_count", m_r - b_r, 2);
        chk("rst_no_short",     m_s - b_s, 0);
        chk("rst_no_double",    m_d - b_d, 0);

        // random stress
        begin
            logic lvl;
            int gap;
            lvl = 1'b1;
            for (int i = 0; i < 1000; i++) begin
                if ($urandom_range(0, 9) < 8) lvl = ~lvl;
                if ($urandom_range(0, 99) < 15) gap = $urandom_range(90, 130);
                else gap = $urandom_range(1, 50);
                strobe(lvl, x);
                idle(gap - 1);
            end
        end
        key_state = 1'b1;
        strobe(1'b1, x);
        idle(300);

        chk("valid_vs_pulses", d_valid, d_pulse);
        chk("valid_vs_model",  d_valid, m_v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
